sa_feature_feeder: RTL and testbench
====================================

// Module: sa_feature_feeder
// PURPOSE
// - Responder for the SA controller's feature-read strobe: while rd_feature_ld_i is high it
//   streams one feature vector per cycle from the feature buffer into the array rows.
// - Applies per-row systolic skew and signals the end of the feature stream on end_feature_o,
//   which drives the controller's end_feature_i.
// - Sits between the feature buffer (sync-read memory) and the row inputs of the systolic array.
// PARAMETERS
// - N_ROWS_ARRAY   4                      rows fed; one I_WIDTH lane per row
// - I_WIDTH        8                      feature element width
// - FEATURE_DEPTH  64                     feature buffer depth, in vectors
// - ADDRS_WIDTH    $clog2(FEATURE_DEPTH)  buffer address width
// - RD_LATENCY     1                      buffer read latency in cycles; must be >= 1
// PORTS
// - clk_i              in   1                       clock
// - general_rst_i      in   1                       synchronous, active-high reset
// - rd_feature_ld_i    in   1                       read-enable strobe from the controller
// - feature_len_i      in   ADDRS_WIDTH+1           vectors per pass; sampled when leaving IDLE
// - mem_rd_en_o        out  1                       buffer read enable (combinational)
// - mem_addrs_o        out  ADDRS_WIDTH             buffer read address (registered counter)
// - mem_data_i         in   N_ROWS_ARRAY*I_WIDTH    read data; row j = bits [(j+1)*I_WIDTH-1 : j*I_WIDTH]
// - feature_o          out  [I_WIDTH-1:0] [0:N_ROWS_ARRAY-1]  skewed row features
// - feature_valid_o    out  1 [0:N_ROWS_ARRAY-1]  per-row valid
// - end_feature_o      out  1                       stream complete (level)
// BEHAVIOUR
// - Reset: state = IDLE.
//   - Reset values: mem_addrs_o = 0, len register = 0, mem_rd_en_o = 0, end_feature_o = 0.
//   - All feature_o = 0 and all feature_valid_o = 0; the valid/skew pipeline is flushed.
//   - Reset mid-stream aborts with no further reads.
// - FSM states: IDLE, STREAM, DRAIN, DONE.
//   - IDLE -> STREAM: rd_feature_ld_i = 1 and feature_len_i != 0. Latch len.
//   - IDLE -> DONE: rd_feature_ld_i = 1 and feature_len_i == 0. No reads are issued.
//   - STREAM -> DRAIN: cycle that issues the read at address len-1.
//   - DRAIN -> DONE: after D cycles, where D = RD_LATENCY + N_ROWS_ARRAY - 1. Counted by the drain counter.
//   - DONE -> IDLE: rd_feature_ld_i = 0. mem_addrs_o returns to 0.
// - Read issue:
//   - mem_rd_en_o = rd_feature_ld_i & (state is IDLE with len != 0, or STREAM).
//   - Each issue reads mem_addrs_o, then mem_addrs_o increments.
//   - rd_feature_ld_i = 0 while in STREAM stalls: no issue, address held, bubble inserted.
// - Data path:
//   - Issue valid is delayed RD_LATENCY cycles to align with mem_data_i.
//   - Row j lane and its valid are then delayed j further cycles through a shift register.
//   - Latency from issue to feature_o[j] is RD_LATENCY + j.
//   - feature_o[j] = 0 whenever feature_valid_o[j] = 0 (bubbles add zero in the MACs).
// - end_feature_o: 1 only in DONE; held until rd_feature_ld_i falls.
//   - The controller's waiting counter runs while it is high.
// - Simultaneous events:
//   - general_rst_i dominates everything.
//   - In DRAIN, rd_feature_ld_i = 0 does not stop the drain; the skew pipeline keeps shifting every cycle.
//   - In DONE, rd_feature_ld_i = 1 issues nothing.
// - Widths: the address counter never exceeds len-1.
//   - feature_len_i > FEATURE_DEPTH is clamped to FEATURE_DEPTH.
// CONFIGURATION
// - FEATURE_SKEW_EN defined: per-row skew of j cycles as above. D = RD_LATENCY + N_ROWS_ARRAY - 1.
// - FEATURE_SKEW_EN undefined: no skew; all rows are presented in the same cycle.
//   - Latency is RD_LATENCY. D = RD_LATENCY.
// TESTING
// - Reset then idle: all outputs 0 every cycle; mem_rd_en_o = 0 with rd_feature_ld_i = 0.
// - feature_len_i = 5, strobe held high, SKEW_EN, RD_LATENCY = 1:
//   - Reads at addresses 0..4 on cycles 0..4.
//   - Row 0 valid on cycles 1..5; row 3 valid on cycles 4..8.
//   - end_feature_o rises on cycle 9.
// - Same as above with rd_feature_ld_i = 0 for 2 cycles after the read of address 2:
//   - Address held at 3; two zero bubbles appear in each row; end_feature_o is 2 cycles later.
// - feature_len_i = 0: end_feature_o = 1 one cycle after the strobe, no reads.
//   - Dropping the strobe -> IDLE, end_feature_o = 0.
// - general_rst_i pulse during STREAM at address 3:
//   - Next cycle all valids = 0 and mem_addrs_o = 0.
//   - A new strobe restarts the read at address 0.
// - FEATURE_SKEW_EN undefined, feature_len_i = 4:
//   - All rows valid on cycles 1..4, identical timing.
//   - end_feature_o on cycle 5.

Source files
------------

// File: rtl/sa_feature_feeder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sa_feature_feeder_if : controller/buffer/array bundle for the feature feeder (rev 1.0)
// ---------------------------------------------------------------------------
interface sa_feature_feeder_if #(
  parameter int N_ROWS_ARRAY = 4,
  parameter int I_WIDTH      = 8,
  parameter int ADDRS_WIDTH  = 6
);
  logic                             rd_feature_ld_i;
  logic [ADDRS_WIDTH:0]             feature_len_i;
  logic                             mem_rd_en_o;
  logic [ADDRS_WIDTH-1:0]           mem_addrs_o;
  logic [N_ROWS_ARRAY*I_WIDTH-1:0]  mem_data_i;
  logic [I_WIDTH-1:0]               feature_o       [0:N_ROWS_ARRAY-1];
  logic                             feature_valid_o [0:N_ROWS_ARRAY-1];
  logic                             end_feature_o;

  modport slave (
    input  rd_feature_ld_i, feature_len_i, mem_data_i,
    output mem_rd_en_o, mem_addrs_o, feature_o, feature_valid_o, end_feature_o
  );

  modport master (
    output rd_feature_ld_i, feature_len_i, mem_data_i,
    input  mem_rd_en_o, mem_addrs_o, feature_o, feature_valid_o, end_feature_o
  );
endinterface
`default_nettype wire

// File: rtl/sa_feature_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sa_feature_feeder : streams feature vectors into array rows with systolic skew;
// per-row skew enabled by macro FEATURE_SKEW_EN (rev 1.0)
// ---------------------------------------------------------------------------
module sa_feature_feeder #(
  parameter int N_ROWS_ARRAY  = 4,
  parameter int I_WIDTH       = 8,
  parameter int FEATURE_DEPTH = 64,
  parameter int ADDRS_WIDTH   = $clog2(FEATURE_DEPTH),
  parameter int RD_LATENCY    = 1
) (
  input logic                clk_i,
  input logic                general_rst_i,
  sa_feature_feeder_if.slave bus
);

`ifdef FEATURE_SKEW_EN
  localparam int DRAIN_CYCLES = RD_LATENCY + N_ROWS_ARRAY - 1;
`else
  localparam int DRAIN_CYCLES = RD_LATENCY;
`endif
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDRS_WIDTH:0] DEPTH_LEN = (ADDRS_WIDTH+1)'(FEATURE_DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDRS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRS_WIDTH:0]   len_q, len_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;
  logic [RD_LATENCY-1:0]  rd_vld_q;

  logic [ADDRS_WIDTH:0]   w_len_in;
  logic [ADDRS_WIDTH:0]   w_len_cur;
  logic                   w_last;
  logic                   w_issue;
  logic                   w_rd_en;
  logic                   w_data_vld;
  logic [N_ROWS_ARRAY-1:0][I_WIDTH-1:0] w_feat;
  logic [N_ROWS_ARRAY-1:0]              w_vld;

  assign w_len_in  = (bus.feature_len_i > DEPTH_LEN) ? DEPTH_LEN : bus.feature_len_i;
  assign w_len_cur = (state_q == IDLE) ? w_len_in : len_q;
  assign w_last    = (addr_q == ADDRS_WIDTH'(w_len_cur - 1'b1));

  always_ff @(posedge clk_i) begin
    if (general_rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      drain_q <= drain_d;
    end
  end

  // The last issue holds the address at len-1 so it never runs past the pass.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    drain_d = drain_q;
    w_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rd_feature_ld_i) begin
          len_d = w_len_in;
          if (w_len_in == '0) begin
            state_d = DONE;
          end else begin
            w_issue = 1'b1;
            if (w_last) begin
              state_d = DRAIN;
              drain_d = '0;
            end else begin
              state_d = STREAM;
              addr_d  = addr_q + 1'b1;
            end
          end
        end
      end
      STREAM: begin
        if (bus.rd_feature_ld_i) begin
          w_issue = 1'b1;
          if (w_last) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        if (!bus.rd_feature_ld_i) begin
          state_d = IDLE;
          addr_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w_rd_en           = w_issue & ~general_rst_i;
  assign bus.mem_rd_en_o   = w_rd_en;
  assign bus.mem_addrs_o   = addr_q;
  assign bus.end_feature_o = (state_q == DONE);

  // Issue strobe delayed to line up with the buffer's read data.
  generate
    if (RD_LATENCY == 1) begin : g_lat_one
      always_ff @(posedge clk_i) begin
        if (general_rst_i) rd_vld_q <= '0;
        else               rd_vld_q <= w_rd_en;
      end
    end else begin : g_lat_many
      always_ff @(posedge clk_i) begin
        if (general_rst_i) rd_vld_q <= '0;
        else               rd_vld_q <= {rd_vld_q[RD_LATENCY-2:0], w_rd_en};
      end
    end
  endgenerate

  assign w_data_vld = rd_vld_q[RD_LATENCY-1];

  generate
    for (genvar j = 0; j < N_ROWS_ARRAY; j++) begin : g_row
      logic [I_WIDTH-1:0] w_lane;
      // Invalid slots carry zero so bubbles contribute nothing in the MACs.
      assign w_lane = w_data_vld ? bus.mem_data_i[j*I_WIDTH +: I_WIDTH] : '0;
`ifdef FEATURE_SKEW_EN
      if (j == 0) begin : g_direct
        assign w_feat[j] = w_lane;
        assign w_vld[j]  = w_data_vld;
      end else begin : g_skew
        logic [j-1:0]              vld_q;
        logic [j-1:0][I_WIDTH-1:0] dat_q;
        if (j == 1) begin : g_one
          always_ff @(posedge clk_i) begin
            if (general_rst_i) begin
              vld_q <= '0;
              dat_q <= '0;
            end else begin
              vld_q <= w_data_vld;
              dat_q <= w_lane;
            end
          end
        end else begin : g_many
          always_ff @(posedge clk_i) begin
            if (general_rst_i) begin
              vld_q <= '0;
              dat_q <= '0;
            end else begin
              vld_q <= {vld_q[j-2:0], w_data_vld};
              dat_q <= {dat_q[j-2:0], w_lane};
            end
          end
        end
        assign w_feat[j] = dat_q[j-1];
        assign w_vld[j]  = vld_q[j-1];
      end
`else
      assign w_feat[j] = w_lane;
      assign w_vld[j]  = w_data_vld;
`endif
    end
  endgenerate

  always_comb begin
    for (int j = 0; j < N_ROWS_ARRAY; j++) begin
      bus.feature_o[j]       = w_feat[j];
      bus.feature_valid_o[j] = w_vld[j];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sa_feature_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sa_feature_feeder : randomized bench for sa_feature_feeder (rev 1.0)
// ---------------------------------------------------------------------------
module tb_sa_feature_feeder;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int L     = 1;
`ifdef FEATURE_SKEW_EN
  localparam int SKEW_STEP = 1;
`else
  localparam int SKEW_STEP = 0;
`endif
  localparam int D    = L + SKEW_STEP * (N - 1);
  localparam int MAXC = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sa_feature_feeder_if #(.N_ROWS_ARRAY(N), .I_WIDTH(W), .ADDRS_WIDTH(AW)) bus ();

  sa_feature_feeder #(
    .N_ROWS_ARRAY (N),
    .I_WIDTH      (W),
    .FEATURE_DEPTH(DEPTH),
    .ADDRS_WIDTH  (AW),
    .RD_LATENCY   (L)
  ) dut (
    .clk_i        (clk),
    .general_rst_i(rst),
    .bus          (bus)
  );

  logic [N*W-1:0] mem [0:DEPTH-1];

  // Sync-read buffer; returns junk when not enabled so output gating is exercised.
  always @(posedge clk)
    bus.mem_data_i <= bus.mem_rd_en_o ? mem[bus.mem_addrs_o] : (N*W)'($urandom);

  int vectors = 0;
  int miscompares = 0;

  bit             ld_pat    [MAXC];
  int             issue_idx [MAXC];
  bit             e_en      [MAXC];
  int             e_addr    [MAXC];
  bit             e_end     [MAXC];
  bit             e_vld     [MAXC][N];
  logic [W-1:0]   e_feat    [MAXC][N];

  // Reference: k-th granted strobe cycle reads vector k; row j sees it L+skew(j) later;
  // end rises D+1 cycles after the last read and holds until the strobe drops.
  function automatic int build_model(input int len_in, input int hold);
    int len, k, t_last, t_end, c_drop, ncyc, c, n, src;
    len = (len_in > DEPTH) ? DEPTH : len_in;
    k = 0; t_last = -1; c = 0; n = 0;
    for (int i = 0; i < MAXC; i++) begin
      issue_idx[i] = -1; e_en[i] = 1'b0; e_end[i] = 1'b0; e_addr[i] = 0;
      for (int j = 0; j < N; j++) begin e_vld[i][j] = 1'b0; e_feat[i][j] = '0; end
    end
    ld_pat[0] = 1'b1;
    if (len == 0) begin
      t_end = 1;
    end else begin
      while (k < len && c < MAXC - 40) begin
        if (ld_pat[c]) begin issue_idx[c] = k; e_en[c] = 1'b1; k++; t_last = c; end
        c++;
      end
      t_end = t_last + D + 1;
    end
    for (int i = (len == 0) ? 1 : t_last + 1; i < t_end; i++) ld_pat[i] = 1'($urandom_range(0, 1));
    for (int i = t_end; i < t_end + hold; i++) ld_pat[i] = 1'b1;
    c_drop = t_end + hold;
    ncyc   = c_drop + D + 3;
    for (int i = c_drop; i < ncyc; i++) ld_pat[i] = 1'b0;
    for (int i = t_end; i <= c_drop; i++) e_end[i] = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      e_addr[i] = (len == 0 || i > c_drop) ? 0 : ((n < len - 1) ? n : len - 1);
      if (issue_idx[i] >= 0) n++;
      for (int j = 0; j < N; j++) begin
        src = i - L - SKEW_STEP * j;
        if (src >= 0 && issue_idx[src] >= 0) begin
          e_vld[i][j]  = 1'b1;
          e_feat[i][j] = mem[issue_idx[src]][j*W +: W];
        end
      end
    end
    return ncyc;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.rd_feature_ld_i = 1'b0;
    bus.feature_len_i   = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 3) rst = 1'b0;
      if (c >= 3) bus.feature_len_i = (AW+1)'($urandom_range(1, 64));
      @(negedge clk);
      if (c == 0) continue;
      vectors++;
      if (bus.mem_rd_en_o !== 1'b0 || bus.mem_addrs_o !== '0 || bus.end_feature_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle c%0d: rd_en=%b addr=%0d end=%b, required 0/0/0",
                 c, bus.mem_rd_en_o, bus.mem_addrs_o, bus.end_feature_o);
      end
      for (int j = 0; j < N; j++) begin
        vectors++;
        if (bus.feature_valid_o[j] !== 1'b0 || bus.feature_o[j] !== '0) begin
          miscompares++;
          $display("FAIL reset_idle c%0d row%0d: valid=%b feat=%h, required 0/00",
                   c, j, bus.feature_valid_o[j], bus.feature_o[j]);
        end
      end
    end
  endtask

  task automatic test_directed();
    int dlen  [4] = '{5, 5, 100, 1};
    int dstal [4] = '{0, 1, 0, 0};
    int dhold [4] = '{2, 1, 0, 3};
    int ncyc;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < MAXC; i++) ld_pat[i] = 1'b1;
      if (dstal[p] != 0) begin ld_pat[3] = 1'b0; ld_pat[4] = 1'b0; end
      ncyc = build_model(dlen[p], dhold[p]);
      for (int c = 0; c < ncyc; c++) begin
        @(posedge clk); #1;
        bus.rd_feature_ld_i = ld_pat[c];
        bus.feature_len_i   = (AW+1)'(dlen[p]);
        @(negedge clk);
        vectors++;
        if (bus.mem_rd_en_o !== e_en[c]) begin
          miscompares++;
          $display("FAIL dir%0d c%0d rd_en: got %b exp %b", p, c, bus.mem_rd_en_o, e_en[c]);
        end
        vectors++;
        if (bus.mem_addrs_o !== AW'(e_addr[c])) begin
          miscompares++;
          $display("FAIL dir%0d c%0d addr: got %0d exp %0d", p, c, bus.mem_addrs_o, e_addr[c]);
        end
        vectors++;
        if (bus.end_feature_o !== e_end[c]) begin
          miscompares++;
          $display("FAIL dir%0d c%0d end: got %b exp %b", p, c, bus.end_feature_o, e_end[c]);
        end
        for (int j = 0; j < N; j++) begin
          vectors++;
          if (bus.feature_valid_o[j] !== e_vld[c][j] || bus.feature_o[j] !== e_feat[c][j]) begin
            miscompares++;
            $display("FAIL dir%0d c%0d row%0d: got valid=%b feat=%h exp valid=%b feat=%h",
                     p, c, j, bus.feature_valid_o[j], bus.feature_o[j], e_vld[c][j], e_feat[c][j]);
          end
        end
      end
    end
  endtask

  task automatic test_zero_len();
    bit zl_ld  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bit zl_end [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      bus.rd_feature_ld_i = zl_ld[c];
      bus.feature_len_i   = '0;
      @(negedge clk);
      vectors++;
      if (bus.end_feature_o !== zl_end[c] || bus.mem_rd_en_o !== 1'b0 || bus.mem_addrs_o !== '0) begin
        miscompares++;
        $display("FAIL zero_len c%0d: end=%b rd_en=%b addr=%0d, required end=%b rd_en=0 addr=0",
                 c, bus.end_feature_o, bus.mem_rd_en_o, bus.mem_addrs_o, zl_end[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      rst                 = (c == 3 || c == 6);
      bus.rd_feature_ld_i = (c != 4 && c != 6 && c != 7);
      bus.feature_len_i   = (c >= 5) ? (AW+1)'(3) : (AW+1)'(8);
      @(negedge clk);
      if (c == 3) begin
        vectors++;
        if (bus.mem_addrs_o !== AW'(3) || bus.mem_rd_en_o !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_mid c3: addr=%0d rd_en=%b, required addr=3 rd_en=0",
                   bus.mem_addrs_o, bus.mem_rd_en_o);
        end
      end
      if (c == 4) begin
        vectors++;
        if (bus.mem_addrs_o !== '0 || bus.mem_rd_en_o !== 1'b0 || bus.end_feature_o !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_mid c4: addr=%0d rd_en=%b end=%b, required 0/0/0",
                   bus.mem_addrs_o, bus.mem_rd_en_o, bus.end_feature_o);
        end
        for (int j = 0; j < N; j++) begin
          vectors++;
          if (bus.feature_valid_o[j] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid c4 row%0d valid: got %b exp 0", j, bus.feature_valid_o[j]);
          end
        end
      end
      if (c == 5) begin
        vectors++;
        if (bus.mem_rd_en_o !== 1'b1 || bus.mem_addrs_o !== '0) begin
          miscompares++;
          $display("FAIL reset_mid restart: rd_en=%b addr=%0d, required rd_en=1 addr=0",
                   bus.mem_rd_en_o, bus.mem_addrs_o);
        end
      end
    end
  endtask

  task automatic test_random();
    int ncyc, len_in, hold;
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = (N*W)'($urandom);
      for (int i = 0; i < MAXC; i++) ld_pat[i] = ($urandom_range(0, 3) != 0);
      len_in = (p == 0) ? 0 : $urandom_range(1, 80);
      hold   = $urandom_range(0, 3);
      ncyc   = build_model(len_in, hold);
      for (int c = 0; c < ncyc; c++) begin
        @(posedge clk); #1;
        bus.rd_feature_ld_i = ld_pat[c];
        bus.feature_len_i   = (AW+1)'(len_in);
        @(negedge clk);
        vectors++;
        if (bus.mem_rd_en_o !== e_en[c]) begin
          miscompares++;
          $display("FAIL rnd%0d c%0d rd_en: got %b exp %b", p, c, bus.mem_rd_en_o, e_en[c]);
        end
        vectors++;
        if (bus.mem_addrs_o !== AW'(e_addr[c])) begin
          miscompares++;
          $display("FAIL rnd%0d c%0d addr: got %0d exp %0d", p, c, bus.mem_addrs_o, e_addr[c]);
        end
        vectors++;
        if (bus.end_feature_o !== e_end[c]) begin
          miscompares++;
          $display("FAIL rnd%0d c%0d end: got %b exp %b", p, c, bus.end_feature_o, e_end[c]);
        end
        for (int j = 0; j < N; j++) begin
          vectors++;
          if (bus.feature_valid_o[j] !== e_vld[c][j] || bus.feature_o[j] !== e_feat[c][j]) begin
            miscompares++;
            $display("FAIL rnd%0d c%0d row%0d: got valid=%b feat=%h exp valid=%b feat=%h",
                     p, c, j, bus.feature_valid_o[j], bus.feature_o[j], e_vld[c][j], e_feat[c][j]);
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.rd_feature_ld_i = 1'b0;
    bus.feature_len_i   = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = (N*W)'($urandom);
    test_reset();
    test_directed();
    test_zero_len();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
